alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_pkg.sv | 19 +
 rtl/gen_alu.sv | 31 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/alu_share_arb.sv | 119 +++++++++++
 tb/tb_alu_share_arb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU opcodes and arbiter FSM states.
package alu_share_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/gen_alu.sv
// Generic N-bit ALU: ADD/SUB with carry/borrow out, bitwise AND/OR with co=0.
module gen_alu
  import alu_share_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [1:0]   f,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] r;

  // Extended-width result so the top bit is carry (ADD) or borrow (SUB).
  always_comb begin
    r = '0;
    case (alu_op_t'(f))
      ADD:     r = {1'b0, a} + {1'b0, b};
      SUB:     r = {1'b0, a} - {1'b0, b};
      AND:     r = {1'b0, a & b};
      OR:      r = {1'b0, a | b};
      default: r = '0;
    endcase
  end

  assign s  = r[N-1:0];
  assign co = r[N];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search begins one past last_grant and wraps around.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  // First requester found at offsets 1..NREQ from last_grant wins.
  always_comb begin
    grant = '0;
    idx   = last_grant;
    any   = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      logic [31:0] c;
      c = (32'(last_grant) + 32'(i)) % 32'(NREQ);
      if (!any && req[IW'(c)]) begin
        grant[IW'(c)] = 1'b1;
        idx           = IW'(c);
        any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates NREQ requesters onto one shared gen_alu; one operation in flight.
// Optional grant statistics: define ALU_SHARE_ARB_STATS_EN.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][1:0]          req_f,
  input  logic [NREQ-1:0][N-1:0]        req_a,
  input  logic [NREQ-1:0][N-1:0]        req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [N-1:0]                  rsp_s,
  output logic                          rsp_co,
  output logic [NREQ-1:0][STAT_W-1:0]   stat_grants
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   cur_id;
  logic [1:0]      op_f;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [N-1:0]    alu_s;
  logic            alu_co;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (gnt),
    .idx        (gnt_idx),
    .any        (gnt_any)
  );

  gen_alu #(.N(N)) u_alu (
    .f  (op_f),
    .a  (op_a),
    .b  (op_b),
    .s  (alu_s),
    .co (alu_co)
  );

  // Accept strobe is combinational in IDLE and suppressed while reset is held.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;

  // Control FSM: capture winner in IDLE, register ALU result in EXEC, hold in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(NREQ - 1);
      cur_id     <= '0;
      op_f       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_s      <= '0;
      rsp_co     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            op_f       <= req_f[gnt_idx];
            op_a       <= req_a[gnt_idx];
            op_b       <= req_b[gnt_idx];
            cur_id     <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_s     <= alu_s;
          rsp_co    <= alu_co;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] cnt;

  // Per-requester saturating grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_ready[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign stat_grants = cnt;
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb (N=8/NREQ=4 plus an N=4/NREQ=2 instance).
module tb_alu_share_arb;
  import alu_share_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  logic [3:0][1:0]  req_f = '0;
  logic [3:0][7:0]  req_a = '0;
  logic [3:0][7:0]  req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_id;
  logic [7:0]       rsp_s;
  logic             rsp_co;
  logic [3:0][15:0] stat_grants;

  logic [1:0]       req_valid4 = '0;
  logic [1:0]       req_ready4;
  logic [1:0][1:0]  req_f4 = '0;
  logic [1:0][3:0]  req_a4 = '0;
  logic [1:0][3:0]  req_b4 = '0;
  logic             rsp_valid4;
  logic             rsp_ready4 = 1'b0;
  logic             rsp_id4;
  logic [3:0]       rsp_s4;
  logic             rsp_co4;
  logic [1:0][15:0] stat_grants4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.N(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_f(req_f), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co),
    .stat_grants(stat_grants)
  );

  alu_share_arb #(.N(4), .NREQ(2)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_f(req_f4), .req_a(req_a4), .req_b(req_b4), .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_s(rsp_s4), .rsp_co(rsp_co4),
    .stat_grants(stat_grants4)
  );

  typedef struct {
    int        id;
    alu_op_t   f;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction on a single requester, starting and ending at an IDLE negedge.
  task automatic do_op(input int id, input alu_op_t f, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic eco);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_f[id] = f;
    req_a[id] = a;
    req_b[id] = b;
    rsp_ready = 1'b0;
    #1;
    chk("accept_ready", 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_id", 32'(rsp_id), 32'(id));
    chk("resp_s", 32'(rsp_s), 32'(es));
    chk("resp_co", 32'(rsp_co), 32'(eco));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("after_handshake_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, ADD, 8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[1] = '{0, ADD, 8'h12, 8'h34, 8'h46, 1'b0};
    vecs[2] = '{1, ADD, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[3] = '{3, SUB, 8'h05, 8'h07, 8'hFE, 1'b1};
    vecs[4] = '{0, SUB, 8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[5] = '{1, SUB, 8'h33, 8'h33, 8'h00, 1'b0};
    vecs[6] = '{2, AND, 8'hCC, 8'hAA, 8'h88, 1'b0};
    vecs[7] = '{3, OR,  8'hCC, 8'hAA, 8'hEE, 1'b0};
    vecs[8] = '{0, OR,  8'h00, 8'h00, 8'h00, 1'b0};
    vecs[9] = '{3, ADD, 8'h80, 8'h80, 8'h00, 1'b1};

    // Reset state, with all requesters asserting to exercise req_ready gating.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_s", 32'(rsp_s), 32'd0);
    chk("rst_rsp_co", 32'(rsp_co), 32'd0);
    chk("rst_stat0", 32'(stat_grants[0]), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Vector table.
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].id, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].co);

    // Round-robin with all requesters valid: grants 0,1,2,3,0 spaced 3 cycles.
    do_reset();
    req_valid = 4'hF;
    for (int r = 0; r < 4; r++) begin
      req_f[r] = ADD;
      req_a[r] = 8'(r);
      req_b[r] = 8'h10;
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (c % 3 == 0) chk("rr_grant", 32'(req_ready), 32'(1) << ((c / 3) % 4));
      else chk("rr_idle_gap", 32'(req_ready), 32'd0);
      if (c % 3 == 2) begin
        chk("rr_rsp_id", 32'(rsp_id), 32'((c / 3) % 4));
        chk("rr_rsp_s", 32'(rsp_s), 32'(8'h10 + 8'((c / 3) % 4)));
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    do_reset();

    // SUB with rsp_ready held low: outputs stable, no new grant.
    req_valid[3] = 1'b1;
    req_f[3] = SUB;
    req_a[3] = 8'h05;
    req_b[3] = 8'h07;
    #1;
    chk("hold_accept", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b0011;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_s", 32'(rsp_s), 32'hFE);
      chk("hold_co", 32'(rsp_co), 32'd1);
      chk("hold_id", 32'(rsp_id), 32'd3);
      chk("hold_no_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("hold_release", 32'(rsp_valid), 32'd0);

    // Reset during EXEC of requester 1 discards the result and restores last_grant.
    do_reset();
    req_valid = 4'b0010;
    req_f[1] = ADD;
    req_a[1] = 8'h77;
    req_b[1] = 8'h11;
    #1;
    chk("rstmid_accept", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_rsp_s", 32'(rsp_s), 32'd0);
    chk("rstmid_rsp_co", 32'(rsp_co), 32'd0);
    chk("rstmid_rsp_id", 32'(rsp_id), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_first_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("rstmid_resp_id", 32'(rsp_id), 32'd1);
    chk("rstmid_resp_s", 32'(rsp_s), 32'h88);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Grant statistics: three grants to requester 0 after reset.
    do_reset();
    for (int k = 0; k < 3; k++) do_op(0, OR, 8'h01, 8'h02, 8'h03, 1'b0);
`ifdef ALU_SHARE_ARB_STATS_EN
    chk("stat_grants0", 32'(stat_grants[0]), 32'd3);
`else
    chk("stat_grants0", 32'(stat_grants[0]), 32'd0);
`endif
    chk("stat_grants1", 32'(stat_grants[1]), 32'd0);

    // N=4 instance: AND 1100 & 1010 = 1000, co=0.
    req_valid4 = 2'b01;
    req_f4[0] = AND;
    req_a4[0] = 4'b1100;
    req_b4[0] = 4'b1010;
    #1;
    chk("n4_accept", 32'(req_ready4), 32'h1);
    @(negedge clk);
    req_valid4 = '0;
    @(negedge clk);
    #1;
    chk("n4_valid", 32'(rsp_valid4), 32'd1);
    chk("n4_s", 32'(rsp_s4), 32'h8);
    chk("n4_co", 32'(rsp_co4), 32'd0);
    rsp_ready4 = 1'b1;
    @(negedge clk);
    rsp_ready4 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
